// File: rtl/sprom_read_arbiter_if.sv
// Bundle of requester-side and ROM-side signals for the shared ROM read arbiter.
// The slave modport is the arbiter's view; the master modport is the
// environment (requesters plus ROM) driving it.
interface sprom_read_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
);
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*ADDR_WIDTH-1:0] addr;
    logic [NUM_REQ-1:0]            rd_valid;
    logic [DATA_WIDTH-1:0]         rd_data;
    logic [ID_W-1:0]               grant_id;
    logic [ADDR_WIDTH-1:0]         rom_address;
    logic [DATA_WIDTH-1:0]         rom_q;

    modport slave (
        input  req, addr, rom_q,
        output rd_valid, rd_data, grant_id, rom_address
    );

    modport master (
        output req, addr, rom_q,
        input  rd_valid, rd_data, grant_id, rom_address
    );
endinterface

// File: rtl/sprom_read_arbiter.sv
// Round-robin arbiter sharing one registered-read ROM among NUM_REQ requesters.
// A grant registers the ROM address and launches a tag down a pipeline of
// ROM_LATENCY+1 stages; when the tag leaves the pipeline the ROM word is
// captured and handed back with a one-cycle valid pulse to the owner.
module sprom_read_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 8,
    parameter int ROM_LATENCY = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    sprom_read_arbiter_if.slave   arb_if
);
    localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int DEPTH = ROM_LATENCY + 1;

    logic [ID_W-1:0]       ptr_q, ptr_d;
    logic [NUM_REQ-1:0]    busy_q, busy_d;
    logic [ADDR_WIDTH-1:0] rom_addr_q, rom_addr_d;
    logic [ID_W-1:0]       grant_q, grant_d;
    logic [NUM_REQ-1:0]    rd_valid_q, rd_valid_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;

    logic [DEPTH-1:0]      tag_vld_q;
    logic [ID_W-1:0]       tag_id_q [DEPTH];

    logic [ADDR_WIDTH-1:0] addr_arr [NUM_REQ];
    logic [NUM_REQ-1:0]    eligible;
    logic                  issue;
    logic [ID_W-1:0]       win;

    genvar gi;

    // Per-requester address split, eligibility and return decode. A requester
    // whose valid pulse is showing this cycle is released at the coming edge,
    // so it may already compete for that same edge.
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign addr_arr[gi]   = arb_if.addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign eligible[gi]   = arb_if.req[gi] & ~(busy_q[gi] & ~rd_valid_q[gi]);
            assign rd_valid_d[gi] = tag_vld_q[DEPTH-1] && (tag_id_q[DEPTH-1] == ID_W'(gi));
        end
    endgenerate

    // Round-robin pick: scan from ptr upward; descending loop lets the
    // nearest eligible index overwrite any farther one.
    always_comb begin
        int              sum;
        logic [ID_W-1:0] idx;
        issue = 1'b0;
        win   = '0;
        sum   = 0;
        idx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            sum = int'(ptr_q) + k;
            if (sum >= NUM_REQ) begin
                sum = sum - NUM_REQ;
            end
            idx = ID_W'(sum);
            if (eligible[idx]) begin
                issue = 1'b1;
                win   = idx;
            end
        end
    end

    // Next-state for grant bookkeeping and the return register.
    always_comb begin
        busy_d     = busy_q & ~rd_valid_q;
        ptr_d      = ptr_q;
        rom_addr_d = rom_addr_q;
        grant_d    = grant_q;
        rd_data_d  = rd_data_q;
        if (issue) begin
            busy_d     = busy_d | (NUM_REQ'(1) << win);
            ptr_d      = (win == ID_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
            rom_addr_d = addr_arr[win];
            grant_d    = win;
        end
        if (tag_vld_q[DEPTH-1]) begin
            rd_data_d = arb_if.rom_q;
        end
    end

    // Arbiter state, ROM address and returned data registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            ptr_q      <= '0;
            busy_q     <= '0;
            rom_addr_q <= '0;
            grant_q    <= '0;
            rd_valid_q <= '0;
            rd_data_q  <= '0;
        end else begin
            ptr_q      <= ptr_d;
            busy_q     <= busy_d;
            rom_addr_q <= rom_addr_d;
            grant_q    <= grant_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    // Tag stage 0 records the grant made at this edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            tag_vld_q[0] <= 1'b0;
            tag_id_q[0]  <= '0;
        end else begin
            tag_vld_q[0] <= issue;
            tag_id_q[0]  <= win;
        end
    end

    // Later tag stages follow the ROM's internal latency.
    generate
        for (gi = 1; gi < DEPTH; gi++) begin : g_tag
            always_ff @(posedge clock) begin
                if (reset) begin
                    tag_vld_q[gi] <= 1'b0;
                    tag_id_q[gi]  <= '0;
                end else begin
                    tag_vld_q[gi] <= tag_vld_q[gi-1];
                    tag_id_q[gi]  <= tag_id_q[gi-1];
                end
            end
        end
    endgenerate

    assign arb_if.rom_address = rom_addr_q;
    assign arb_if.grant_id    = grant_q;
    assign arb_if.rd_valid    = rd_valid_q;
    assign arb_if.rd_data     = rd_data_q;
endmodule

// File: tb/tb_sprom_read_arbiter.sv
// Bench for the shared ROM read arbiter: directed scenarios, a vector table
// for the four-way contention case, and a random phase checked against a
// cycle-count scoreboard model. A second instance covers ROM_LATENCY=3.
module tb_sprom_read_arbiter;
    localparam int NR   = 4;
    localparam int AW   = 8;
    localparam int DW   = 8;
    localparam int LAT  = 1;
    localparam int LAT3 = 3;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    sprom_read_arbiter_if #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus1 ();
    sprom_read_arbiter_if #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus3 ();

    sprom_read_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ROM_LATENCY(LAT))
        dut (.clock(clock), .reset(reset), .arb_if(bus1));
    sprom_read_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ROM_LATENCY(LAT3))
        dut3 (.clock(clock), .reset(reset), .arb_if(bus3));

    // ROM contents and behavioural ROMs with registered read of given latency
    logic [DW-1:0] rom [256];
    logic [DW-1:0] q1_pipe [LAT];
    logic [DW-1:0] q3_pipe [LAT3];

    always @(posedge clock) begin
        q1_pipe[0] <= rom[bus1.rom_address];
        for (int k = 1; k < LAT; k++) q1_pipe[k] <= q1_pipe[k-1];
    end
    always @(posedge clock) begin
        q3_pipe[0] <= rom[bus3.rom_address];
        for (int k = 1; k < LAT3; k++) q3_pipe[k] <= q3_pipe[k-1];
    end
    assign bus1.rom_q = q1_pipe[LAT-1];
    assign bus3.rom_q = q3_pipe[LAT3-1];

    int checks = 0;
    int errors = 0;

    // Scoreboard model: edge counter, per-requester "free from edge" numbers,
    // and a list of pending returns with the edge at which they appear.
    typedef struct { int due; int id; logic [AW-1:0] a; } pend_t;
    pend_t         pend[$];
    int            cyc = 0;
    int            free_at [NR];
    int            ptr_m = 0;
    logic [NR-1:0] exp_valid;
    logic [DW-1:0] exp_data;
    logic [AW-1:0] exp_rom;
    int            exp_grant;
    logic          was_reset;

    typedef struct {
        logic [NR-1:0] req;
        logic [NR-1:0] exp_valid;
        logic [AW-1:0] exp_rom;
        int            exp_grant;
        logic [AW-1:0] data_addr;
    } vec_t;
    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
        checks++;
        if (act !== req_v) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", name, act, req_v, cyc);
        end
    endtask

    task automatic set_req(input int i, input logic v, input logic [AW-1:0] a);
        bus1.req[i] = v;
        bus1.addr[i*AW +: AW] = a;
    endtask

    // Apply the specification's rules to the inputs present before the edge.
    task automatic model_edge();
        int w;
        int i;
        exp_valid = '0;
        was_reset = reset;
        if (reset) begin
            pend.delete();
            foreach (free_at[j]) free_at[j] = 0;
            ptr_m = 0; exp_rom = '0; exp_grant = 0; exp_data = '0;
            cyc++;
            return;
        end
        for (int j = pend.size() - 1; j >= 0; j--) begin
            if (pend[j].due == cyc) begin
                exp_valid[pend[j].id] = 1'b1;
                exp_data = rom[pend[j].a];
                pend.delete(j);
            end
        end
        w = -1;
        for (int k = 0; k < NR; k++) begin
            i = (ptr_m + k) % NR;
            if (w < 0 && bus1.req[i] && free_at[i] <= cyc) w = i;
        end
        if (w >= 0) begin
            exp_rom   = bus1.addr[w*AW +: AW];
            exp_grant = w;
            free_at[w] = cyc + LAT + 2;
            ptr_m     = (w + 1) % NR;
            pend.push_back('{cyc + LAT + 1, w, bus1.addr[w*AW +: AW]});
        end
        cyc++;
    endtask

    // One clock edge: update the model, then compare outputs 1 time unit later.
    task automatic step();
        model_edge();
        @(posedge clock);
        #1;
        check("rd_valid", 32'(bus1.rd_valid), 32'(exp_valid));
        check("grant_id", 32'(bus1.grant_id), 32'(exp_grant));
        check("rom_address", 32'(bus1.rom_address), 32'(exp_rom));
        if (exp_valid != '0 || was_reset)
            check("rd_data", 32'(bus1.rd_data), 32'(exp_data));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        int cnt [NR];
        int total, last_id, alt_bad, seen3, vcount;
        logic [AW-1:0] nxt [NR];
        logic          active [NR];

        for (int a = 0; a < 256; a++) rom[a] = DW'((a * 37 + 11) ^ (a >> 2));
        rom[8'h12] = 8'hA5;
        reset = 1'b1;
        bus1.req = '0; bus1.addr = '0;
        bus3.req = '0; bus3.addr = '0;
        foreach (free_at[j]) free_at[j] = 0;

        // Reset state
        step();
        step();
        check("reset_rd_valid", 32'(bus1.rd_valid), 32'h0);
        check("reset_rom_address", 32'(bus1.rom_address), 32'h0);
        check("reset_rd_data", 32'(bus1.rd_data), 32'h0);
        reset = 1'b0;

        // Single read of 0x12
        set_req(0, 1'b1, 8'h12);
        step();
        check("single_addr", 32'(bus1.rom_address), 32'h12);
        step();
        check("single_wait", 32'(bus1.rd_valid), 32'h0);
        step();
        check("single_valid", 32'(bus1.rd_valid), 32'h1);
        check("single_data", 32'(bus1.rd_data), 32'hA5);
        set_req(0, 1'b0, 8'h00);
        for (int k = 0; k < 4; k++) begin
            step();
            check("single_quiet", 32'(bus1.rd_valid), 32'h0);
        end

        // Four-way contention vector table
        vecs[0] = '{4'b1111, 4'b0000, 8'h10, 0, 8'h00};
        vecs[1] = '{4'b1111, 4'b0000, 8'h11, 1, 8'h00};
        vecs[2] = '{4'b1111, 4'b0001, 8'h12, 2, 8'h10};
        vecs[3] = '{4'b1110, 4'b0010, 8'h13, 3, 8'h11};
        vecs[4] = '{4'b1100, 4'b0100, 8'h13, 3, 8'h12};
        vecs[5] = '{4'b1000, 4'b1000, 8'h13, 3, 8'h13};
        vecs[6] = '{4'b0000, 4'b0000, 8'h13, 3, 8'h00};
        do_reset();
        for (int i = 0; i < NR; i++) bus1.addr[i*AW +: AW] = AW'(8'h10 + i);
        for (int v = 0; v < 7; v++) begin
            bus1.req = vecs[v].req;
            step();
            check("tbl_rd_valid", 32'(bus1.rd_valid), 32'(vecs[v].exp_valid));
            check("tbl_rom_address", 32'(bus1.rom_address), 32'(vecs[v].exp_rom));
            check("tbl_grant_id", 32'(bus1.grant_id), 32'(vecs[v].exp_grant));
            if (vecs[v].exp_valid != '0)
                check("tbl_rd_data", 32'(bus1.rd_data), 32'(rom[vecs[v].data_addr]));
        end

        // Fairness: requesters 0 and 2 held, new address after each valid
        do_reset();
        nxt[0] = 8'h50; nxt[2] = 8'h60;
        set_req(0, 1'b1, nxt[0]);
        set_req(2, 1'b1, nxt[2]);
        cnt[0] = 0; cnt[2] = 0; total = 0; last_id = -1; alt_bad = 0;
        for (int c = 0; c < 200 && total < 20; c++) begin
            step();
            for (int i = 0; i < NR; i += 2) begin
                if (bus1.rd_valid[i]) begin
                    cnt[i]++; total++;
                    if (last_id == i) alt_bad++;
                    last_id = i;
                    nxt[i] = nxt[i] + 1'b1;
                    set_req(i, 1'b1, nxt[i]);
                end
            end
        end
        check("fair_total", 32'(total), 32'd20);
        check("fair_alternate", 32'(alt_bad), 32'd0);
        check("fair_req0", 32'(cnt[0]), 32'd10);
        check("fair_req2", 32'(cnt[2]), 32'd10);
        bus1.req = '0;
        step(); step(); step();

        // Back-to-back reads by requester 1
        do_reset();
        set_req(1, 1'b1, 8'h20);
        step();
        step();
        step();
        check("b2b_first_valid", 32'(bus1.rd_valid), 32'h2);
        set_req(1, 1'b1, 8'h21);
        step();
        check("b2b_regrant_addr", 32'(bus1.rom_address), 32'h21);
        check("b2b_regrant_id", 32'(bus1.grant_id), 32'h1);
        step();
        check("b2b_no_dup", 32'(bus1.rd_valid), 32'h0);
        step();
        check("b2b_second_valid", 32'(bus1.rd_valid), 32'h2);
        check("b2b_second_data", 32'(bus1.rd_data), 32'(rom[8'h21]));
        bus1.req = '0;
        step(); step();

        // Withdrawal: req[3] pulsed once while requester 1 wins
        do_reset();
        set_req(0, 1'b1, 8'h30);
        step();
        set_req(1, 1'b1, 8'h31);
        set_req(3, 1'b1, 8'h33);
        step();
        set_req(3, 1'b0, 8'h00);
        seen3 = 0;
        for (int k = 0; k < 6; k++) begin
            step();
            if (bus1.rd_valid[3]) seen3++;
            if (bus1.rd_valid[0]) set_req(0, 1'b0, 8'h00);
            if (bus1.rd_valid[1]) set_req(1, 1'b0, 8'h00);
        end
        check("withdraw_no_valid3", 32'(seen3), 32'd0);

        // Reset one cycle after a grant cancels the read
        do_reset();
        set_req(2, 1'b1, 8'h40);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("cancel_rd_valid", 32'(bus1.rd_valid), 32'h0);
        check("cancel_rom_address", 32'(bus1.rom_address), 32'h0);
        check("cancel_grant_id", 32'(bus1.grant_id), 32'h0);
        step();
        check("cancel_regrant", 32'(bus1.rom_address), 32'h40);
        vcount = 0;
        for (int k = 0; k < 4; k++) begin
            step();
            if (bus1.rd_valid[2]) begin
                vcount++;
                set_req(2, 1'b0, 8'h00);
            end
        end
        check("cancel_one_pulse", 32'(vcount), 32'd1);

        // Random phase against the scoreboard model
        do_reset();
        foreach (active[i]) active[i] = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 299) == 0);
            step();
            for (int i = 0; i < NR; i++) begin
                if (bus1.rd_valid[i] || (active[i] && $urandom_range(0, 49) == 0)) begin
                    active[i] = 1'b0;
                    set_req(i, 1'b0, AW'($urandom));
                end
                if (!active[i] && $urandom_range(0, 2) == 0) begin
                    active[i] = 1'b1;
                    set_req(i, 1'b1, AW'($urandom));
                end
            end
        end
        reset = 1'b0;
        bus1.req = '0;
        for (int k = 0; k < 6; k++) step();

        // ROM_LATENCY=3 instance: single read of 0x7F
        bus3.req = 4'b0001;
        bus3.addr[0 +: AW] = 8'h7F;
        for (int k = 0; k < 6; k++) begin
            step();
            if (k == 0) check("lat3_addr", 32'(bus3.rom_address), 32'h7F);
            if (k == 4) begin
                check("lat3_valid", 32'(bus3.rd_valid), 32'h1);
                check("lat3_data", 32'(bus3.rd_data), 32'(rom[8'h7F]));
                bus3.req = '0;
            end else begin
                check("lat3_quiet", 32'(bus3.rd_valid), 32'h0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
